// File: rtl/mac_seq_pkg.sv
// Shared definitions for the MAC operand sequencer: FSM state encoding and
// the accumulator width derivation used by both the sequencer and its parent.
package mac_seq_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    FEED    = 3'd2,
    DRAIN   = 3'd3,
    CAPTURE = 3'd4,
    DONE    = 3'd5
  } seq_state_e;

  // Wide enough for 2**data_width products of two full-scale operands.
  function automatic int acc_width(input int data_width);
    return 3 * data_width;
  endfunction

endpackage

// File: rtl/mac_operand_sequencer.sv
// Pulls paired A/B operands, drives one MAC through a VEC_LEN dot product,
// then captures the accumulated sum onto a valid/ready result port.
module mac_operand_sequencer
  import mac_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int VEC_LEN    = 8,
  parameter int ACC_WIDTH  = acc_width(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] a_data,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [DATA_WIDTH-1:0] b_data,
  input  logic                  b_valid,
  output logic                  b_ready,
  output logic                  mac_en,
  output logic                  mac_clr,
  output logic [DATA_WIDTH-1:0] mac_a,
  output logic [DATA_WIDTH-1:0] mac_b,
  input  logic [ACC_WIDTH-1:0]  mac_cout,
  output logic [ACC_WIDTH-1:0]  res_data,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic                  busy
);

  localparam int CNT_W = $clog2(VEC_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(VEC_LEN - 1);

  seq_state_e             state_reg, state_next;
  logic [CNT_W-1:0]       count_reg, count_next;
  logic                   mac_en_next, mac_clr_next;
  logic [DATA_WIDTH-1:0]  mac_a_next, mac_b_next;
  logic [ACC_WIDTH-1:0]   res_data_next;
  logic                   res_valid_next;
  logic                   pop;

  // Both streams must be valid so A and B always pop as a matched pair.
  assign pop = (state_reg == FEED) && a_valid && b_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      count_reg <= '0;
      mac_en    <= 1'b0;
      mac_clr   <= 1'b0;
      mac_a     <= '0;
      mac_b     <= '0;
      res_data  <= '0;
      res_valid <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      mac_en    <= mac_en_next;
      mac_clr   <= mac_clr_next;
      mac_a     <= mac_a_next;
      mac_b     <= mac_b_next;
      res_data  <= res_data_next;
      res_valid <= res_valid_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    unique case (state_reg)
      IDLE:    if (start) state_next = CLEAR;
      CLEAR: begin
        count_next = '0;
        state_next = FEED;
      end
      FEED: begin
        if (pop) begin
          count_next = count_reg + CNT_W'(1);
          if (count_reg == LAST_IDX) state_next = DRAIN;
        end
      end
      DRAIN:   state_next = CAPTURE;
      CAPTURE: state_next = DONE;
      DONE:    if (res_valid && res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    a_ready        = pop;
    b_ready        = pop;
    busy           = (state_reg != IDLE);
    mac_clr_next   = (state_reg == IDLE) && start;
    mac_en_next    = pop;
    mac_a_next     = pop ? a_data : mac_a;
    mac_b_next     = pop ? b_data : mac_b;
    res_data_next  = res_data;
    res_valid_next = res_valid;
    // mac_cout is sampled one edge after DRAIN so the last pair is included.
    if (state_reg == CAPTURE) begin
      res_data_next  = mac_cout;
      res_valid_next = 1'b1;
    end else if (state_reg == DONE && res_valid && res_ready) begin
      res_valid_next = 1'b0;
    end
  end

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Bench for mac_operand_sequencer with a behavioural MAC attached; expected
// dot products are queued at stimulus time and popped when res_valid rises.
module tb_mac_operand_sequencer;
  import mac_seq_pkg::*;

  localparam int DW = 8;
  localparam int VL = 4;
  localparam int AW = acc_width(DW);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] a_data = '0, b_data = '0;
  logic          a_valid = 1'b0, b_valid = 1'b0;
  logic          a_ready, b_ready;
  logic          mac_en, mac_clr;
  logic [DW-1:0] mac_a, mac_b;
  logic [AW-1:0] mac_cout;
  logic [AW-1:0] res_data;
  logic          res_valid;
  logic          res_ready = 1'b1;
  logic          busy;

  int total = 0;
  int bad   = 0;
  logic [AW-1:0] sb [$];

  logic [DW-1:0] seq_a   [VL] = '{8'd1, 8'd2, 8'd3, 8'd4};
  logic [DW-1:0] seq_b   [VL] = '{8'd5, 8'd6, 8'd7, 8'd8};
  logic [DW-1:0] seq_max [VL] = '{8'd255, 8'd255, 8'd255, 8'd255};
  logic [DW-1:0] seq_one [VL] = '{8'd1, 8'd1, 8'd1, 8'd1};

  always #5 clk = ~clk;

  mac_operand_sequencer #(
    .DATA_WIDTH(DW),
    .VEC_LEN   (VL),
    .ACC_WIDTH (AW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a_data   (a_data),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .b_data   (b_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .mac_en   (mac_en),
    .mac_clr  (mac_clr),
    .mac_a    (mac_a),
    .mac_b    (mac_b),
    .mac_cout (mac_cout),
    .res_data (res_data),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .busy     (busy)
  );

  // Behavioural MAC sharing rst_n with the sequencer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       mac_cout <= '0;
    else if (mac_clr) mac_cout <= '0;
    else if (mac_en)  mac_cout <= mac_cout + AW'(mac_a) * AW'(mac_b);
  end

  always @(negedge clk) begin
    if (rst_n) begin
      total++;
      if ((mac_en && mac_clr) || ((a_ready || b_ready) && !busy)) begin
        bad++;
        $display("FAIL invariant: mac_en=%b mac_clr=%b a_ready=%b b_ready=%b busy=%b required no clr+en overlap, no ready while idle",
                 mac_en, mac_clr, a_ready, b_ready, busy);
      end
    end
  end

  // Runs one dot product; stall_after/stall_len drop b_valid after a given pop,
  // abort_after pulls rst_n low in FEED once that many pops have happened.
  task automatic drive_job(input logic [DW-1:0] av [VL], input logic [DW-1:0] bv [VL],
                           input int stall_after, input int stall_len,
                           input int abort_after, input int exp_lat, input string name);
    int idx, pops, edges, stall_left;
    logic pop, stall_edge;
    logic [AW-1:0] exp_sum, got_exp;
    exp_sum = '0;
    for (int i = 0; i < VL; i++) exp_sum += AW'(av[i]) * AW'(bv[i]);
    sb.push_back(exp_sum);
    idx = 0; pops = 0; edges = 0; stall_left = 0;
    @(negedge clk);
    start = 1'b1; a_data = av[0]; b_data = bv[0]; a_valid = 1'b1; b_valid = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (res_valid !== 1'b1 && edges < 100) begin
      @(negedge clk);
      pop = a_ready && a_valid && b_valid;
      stall_edge = (stall_left > 0);
      total++;
      if (a_ready !== b_ready || (stall_edge && a_ready !== 1'b0)) begin
        bad++;
        $display("FAIL %s ready: a_ready=%b b_ready=%b stall=%b required equal and low while stalled",
                 name, a_ready, b_ready, stall_edge);
      end
      @(posedge clk); #1;
      edges++;
      if (stall_edge) begin
        total++;
        if (mac_en !== 1'b0) begin
          bad++;
          $display("FAIL %s stall_en: mac_en=%b required 0", name, mac_en);
        end
      end
      if (pop) begin
        pops++; idx++;
        if (pops == stall_after) stall_left = stall_len;
      end else if (stall_left > 0) begin
        stall_left--;
      end
      if (idx < VL) begin a_data = av[idx]; b_data = bv[idx]; end
      a_valid = (idx < VL);
      b_valid = (idx < VL) && (stall_left == 0);
      if (abort_after > 0 && pops == abort_after) begin
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({mac_en, mac_clr, mac_a, mac_b, res_data, res_valid, a_ready, b_ready, busy} !== '0) begin
          bad++;
          $display("FAIL %s async_reset: en=%b clr=%b a=%0d b=%0d res=%0d rv=%b ar=%b br=%b busy=%b required all 0",
                   name, mac_en, mac_clr, mac_a, mac_b, res_data, res_valid, a_ready, b_ready, busy);
        end
        void'(sb.pop_back());
        a_valid = 1'b0; b_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        $display("%s: aborted by reset after %0d pops", name, pops);
        return;
      end
    end
    got_exp = sb.pop_front();
    total++;
    if (res_valid !== 1'b1 || edges != exp_lat || pops != VL || res_data !== got_exp) begin
      bad++;
      $display("FAIL %s result: res_valid=%b lat=%0d pops=%0d res_data=%0d required valid=1 lat=%0d pops=%0d res_data=%0d",
               name, res_valid, edges, pops, res_data, exp_lat, VL, got_exp);
    end else begin
      $display("%s: res_data=%0d latency=%0d pops=%0d", name, res_data, edges, pops);
    end
  endtask

  task automatic test_reset();
    #3;
    total++;
    if ({mac_en, mac_clr, mac_a, mac_b, res_data, res_valid, a_ready, b_ready, busy} !== '0) begin
      bad++;
      $display("FAIL reset_init: outputs not all zero (busy=%b rv=%b res=%0d)", busy, res_valid, res_data);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    res_ready = 1'b0;
    drive_job(seq_a, seq_b, 0, 0, 0, VL + 3, "reset_prerun");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({mac_en, mac_clr, mac_a, mac_b, res_data, res_valid, a_ready, b_ready, busy} !== '0) begin
      bad++;
      $display("FAIL reset_done: res_data=%0d res_valid=%b busy=%b mac_a=%0d required all 0",
               res_data, res_valid, busy, mac_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    res_ready = 1'b1;
    $display("reset: outputs cleared in DONE");
  endtask

  task automatic wait_idle(input string name);
    @(posedge clk); #1;
    total++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s return_idle: res_valid=%b busy=%b required 0 0", name, res_valid, busy);
    end
  endtask

  task automatic test_basic();
    drive_job(seq_a, seq_b, 0, 0, 0, VL + 3, "basic");
    wait_idle("basic");
  endtask

  task automatic test_stall();
    drive_job(seq_a, seq_b, 2, 3, 0, VL + 6, "stall");
    wait_idle("stall");
  endtask

  task automatic test_max();
    drive_job(seq_max, seq_max, 0, 0, 0, VL + 3, "max");
    wait_idle("max");
  endtask

  task automatic test_hold();
    res_ready = 1'b0;
    drive_job(seq_a, seq_b, 0, 0, 0, VL + 3, "hold");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start = (i == 2);
      @(posedge clk); #1;
      start = 1'b0;
      total++;
      if (res_valid !== 1'b1 || res_data !== AW'(70) || busy !== 1'b1) begin
        bad++;
        $display("FAIL hold_cycle%0d: res_valid=%b res_data=%0d busy=%b required 1 70 1",
                 i, res_valid, res_data, busy);
      end
    end
    @(negedge clk);
    res_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    total++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL hold_handshake: res_valid=%b busy=%b required 0 0", res_valid, busy);
    end
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b0 || mac_clr !== 1'b0) begin
      bad++;
      $display("FAIL hold_start_ignored: busy=%b mac_clr=%b required 0 0", busy, mac_clr);
    end
    $display("hold: result held 5 cycles, start ignored");
    drive_job(seq_one, seq_one, 0, 0, 0, VL + 3, "hold_rerun");
    wait_idle("hold_rerun");
  endtask

  task automatic test_async_reset();
    drive_job(seq_a, seq_b, 0, 0, 2, VL + 3, "abort");
    drive_job(seq_a, seq_b, 0, 0, 0, VL + 3, "after_abort");
    wait_idle("after_abort");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_max();
    test_hold();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
